// File: rtl/spi_byte_master_pkg.sv
// Types shared by the SPI controller and its byte shift engine.
package pack_1_t;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_GEN  = 2'd1,
        SPI_DONE = 2'd2
    } spi_fsm;

    typedef enum logic [2:0] {
        TOP_IDLE   = 3'd0,
        TOP_CONFIG = 3'd1,
        TOP_COMM   = 3'd2,
        TOP_READ   = 3'd3,
        TOP_WAIT   = 3'd4
    } top_fsm;

    // Divider counter is at least one bit, even for CLK_DIV = 1.
    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/spi_byte_master_sclk_gen.sv
// SPI mode-0 clock divider with rise/fall strobes aligned to each toggle.
module spi_sclk_gen
    import pack_1_t::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CW = div_w(CLK_DIV);
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    assign tick = en_i && (div_q == TC);

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    // Strobes are high in the cycle whose closing edge toggles sclk.
    assign rise_tick_o = tick && !sclk_q;
    assign fall_tick_o = tick && sclk_q;
    assign sclk_o      = sclk_q;

endmodule

// File: rtl/spi_byte_master.sv
// Byte-level SPI mode-0 master: shifts MSB-first, returns rx with done.
module spi_byte_master
    import pack_1_t::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              hold_cs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST = EW'(2 * DATA_W - 1);

    spi_fsm            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rsh_q, rsh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              hold_q, hold_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              gen_en, rise, fall;
    logic              accept, last;

    assign gen_en = (state_q == SPI_GEN);
    assign accept = (state_q == SPI_IDLE) && start;
    assign last   = fall && (edge_q == LAST);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (gen_en),
        .sclk_o     (sclk),
        .rise_tick_o(rise),
        .fall_tick_o(fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SPI_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SPI_IDLE: if (start) state_d = SPI_GEN;
            SPI_GEN:  if (last)  state_d = SPI_DONE;
            SPI_DONE: state_d = SPI_IDLE;
            default:  state_d = SPI_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            SPI_GEN:  busy = 1'b1;
            SPI_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_d   = tx_q;
        rsh_d  = rsh_q;
        rx_d   = rx_q;
        edge_d = edge_q;
        hold_d = hold_q;
        cs_n_d = cs_n_q;
        mosi_d = mosi_q;
        if (accept) begin
            tx_d   = tx_data;
            hold_d = hold_cs;
            cs_n_d = 1'b0;
            mosi_d = tx_data[DATA_W-1];
            edge_d = '0;
        end
        if (gen_en) begin
            if (rise || fall) edge_d = edge_q + EW'(1);
            if (rise) rsh_d = {rsh_q[DATA_W-2:0], miso};
            // No shift on the final fall so mosi keeps the LSB.
            if (fall && (edge_q < LAST)) begin
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                mosi_d = tx_q[DATA_W-2];
            end
            if (last) rx_d = rsh_q;
        end
        if ((state_q == SPI_DONE) && !hold_q) cs_n_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= '0;
            rsh_q  <= '0;
            rx_q   <= '0;
            edge_q <= '0;
            hold_q <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rsh_q  <= rsh_d;
            rx_q   <= rx_d;
            edge_q <= edge_d;
            hold_q <= hold_d;
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
        end
    end

    assign rx_data = rx_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule
